// File: rtl/mcs4_cycle_seq_pkg.sv
// Shared MCS-4 types for the cycle sequencer: phase encoding, instruction words
// and the opcode classifiers used to sequence two-word instructions.
package mcs4;

  localparam int Cycles_per_instruction = 8;
  localparam int Max_clk_div            = 16;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef struct packed {
    logic [3:0] opr;
    logic [3:0] opa;
  } instr_t;

  typedef struct packed {
    logic [3:0] op_b;
    logic [3:0] op_c;
  } instr2_t;

  // FIN counts as two-word: its second cycle is the indirect fetch.
  function automatic logic is_two_word(instr_t i);
    case (i.opr)
      4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
      4'h2, 4'h3:             return !i.opa[0];
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_fin(instr_t i);
    return (i.opr == 4'h3) && !i.opa[0];
  endfunction

  function automatic logic is_src(instr_t i);
    return (i.opr == 4'h2) && i.opa[0];
  endfunction

  function automatic logic is_io(instr_t i);
    return i.opr == 4'hE;
  endfunction

endpackage

// File: rtl/mcs4_cycle_seq_if.sv
// Bus/strobe bundle between the cycle sequencer (master) and the core datapath (slave).
// Optional stop handshake is present when MCS4_STOP_EN is defined.
interface mcs4_cycle_seq_if;
  import mcs4::*;

  logic       run_en;
  logic [3:0] data_in;
  instr_cyc_t cyc;
  logic       phase_tick;
  logic       sync;
  instr_t     instr;
  instr2_t    instr2;
  logic       second_cycle;
  logic       fin_cycle;
  logic       pc_inc;
  logic       cm_rom;
  logic       cm_ram;
  logic       instr_done;
`ifdef MCS4_STOP_EN
  logic       stop_req;
  logic       stop_ack;
`endif

  modport master (
    input  run_en, data_in,
`ifdef MCS4_STOP_EN
    input  stop_req,
    output stop_ack,
`endif
    output cyc, phase_tick, sync, instr, instr2, second_cycle, fin_cycle,
           pc_inc, cm_rom, cm_ram, instr_done
  );

  modport slave (
    output run_en, data_in,
`ifdef MCS4_STOP_EN
    output stop_req,
    input  stop_ack,
`endif
    input  cyc, phase_tick, sync, instr, instr2, second_cycle, fin_cycle,
           pc_inc, cm_rom, cm_ram, instr_done
  );

endinterface

// File: rtl/mcs4_cycle_seq_prescaler.sv
// Phase tick generator: one tick every Clk_div enabled clocks, count frozen while disabled.
module mcs4_phase_prescaler import mcs4::*; #(
  parameter int Clk_div = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  output logic phase_tick
);

  localparam int              Cw   = $clog2(Max_clk_div);
  localparam logic [Cw-1:0]   Last = Cw'(Clk_div - 1);

  logic [Cw-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (run_en) begin
      count <= (count == Last) ? '0 : count + 1'b1;
    end
  end

  assign phase_tick = run_en && !rst && (count == Last);

endmodule

// File: rtl/mcs4_cycle_seq.sv
// MCS-4 instruction-cycle sequencer: eight-phase machine cycle, OPR/OPA latching,
// two-word sequencing and CM strobes. Optional stop handshake: MCS4_STOP_EN.
module mcs4_cycle_seq import mcs4::*; #(
  parameter int Clk_div                = 1,
  parameter int Cycles_per_instruction = mcs4::Cycles_per_instruction
) (
  input logic              clk,
  input logic              rst,
  mcs4_cycle_seq_if.master bus
);

  if (Cycles_per_instruction != mcs4::Cycles_per_instruction) begin : g_bad_cpi
    $error("mcs4_cycle_seq: Cycles_per_instruction must be 8");
  end
  if (Clk_div < 1 || Clk_div > Max_clk_div) begin : g_bad_div
    $error("mcs4_cycle_seq: Clk_div must be in 1..16");
  end

  instr_cyc_t cyc;
  instr_t     instr;
  instr2_t    instr2;
  logic       second_cycle;
  logic       fin_cycle;
  logic       tick;
  logic       run_gate;
  logic       done_now;

`ifdef MCS4_STOP_EN
  logic stopped;
  assign run_gate     = bus.run_en && !stopped;
  assign bus.stop_ack = stopped;
`else
  assign run_gate = bus.run_en;
`endif

  mcs4_phase_prescaler #(.Clk_div(Clk_div)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .run_en     (run_gate),
    .phase_tick (tick)
  );

  assign done_now = tick && (cyc == X3) && (second_cycle || !is_two_word(instr));

  // The second-cycle flags are decided on the X3 exit, so a stop can only land between instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc          <= A1;
      instr        <= '0;
      instr2       <= '0;
      second_cycle <= 1'b0;
      fin_cycle    <= 1'b0;
`ifdef MCS4_STOP_EN
      stopped      <= 1'b0;
`endif
    end else begin
`ifdef MCS4_STOP_EN
      if (stopped) begin
        if (!bus.stop_req) stopped <= 1'b0;
      end else
`endif
      if (tick) begin
        cyc <= instr_cyc_t'(cyc + 3'd1);
        case (cyc)
          M1: begin
            if (second_cycle) instr2.op_b <= bus.data_in;
            else              instr.opr   <= bus.data_in;
          end
          M2: begin
            if (second_cycle) instr2.op_c <= bus.data_in;
            else              instr.opa   <= bus.data_in;
          end
          X3: begin
            if (second_cycle) begin
              second_cycle <= 1'b0;
              fin_cycle    <= 1'b0;
            end else begin
              second_cycle <= is_two_word(instr);
              fin_cycle    <= is_fin(instr);
            end
`ifdef MCS4_STOP_EN
            if (done_now && bus.stop_req) stopped <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cyc          = cyc;
  assign bus.phase_tick   = tick;
  assign bus.sync         = (cyc == X3);
  assign bus.instr        = instr;
  assign bus.instr2       = instr2;
  assign bus.second_cycle = second_cycle;
  assign bus.fin_cycle    = fin_cycle;
  assign bus.pc_inc       = tick && (cyc == M2) && !fin_cycle;
  assign bus.instr_done   = done_now;
  assign bus.cm_rom       = (cyc == A3)
                         || ((cyc == M2) && !second_cycle && is_io(instr))
                         || ((cyc == X2) && !second_cycle && is_src(instr));
  assign bus.cm_ram       = bus.cm_rom;

endmodule

// File: tb/tb_mcs4_cycle_seq.sv
// Bench for mcs4_cycle_seq: Clk_div=1 and Clk_div=3 instances checked every cycle
// against an instruction-level model, plus directed literal expectations.
module tb_mcs4_cycle_seq;
  import mcs4::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic [3:0] data_in;
  logic       stop_req;

  int vectors     = 0;
  int miscompares = 0;
  int pc_cnt, done_cnt, sync_cnt, cm_rom_cnt, cm_ram_cnt;

  always #5 clk = ~clk;

  mcs4_cycle_seq_if bus1();
  mcs4_cycle_seq_if bus3();

  assign bus1.run_en  = run_en;
  assign bus1.data_in = data_in;
  assign bus3.run_en  = run_en;
  assign bus3.data_in = data_in;
`ifdef MCS4_STOP_EN
  assign bus1.stop_req = stop_req;
  assign bus3.stop_req = stop_req;
`endif

  mcs4_cycle_seq #(.Clk_div(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mcs4_cycle_seq #(.Clk_div(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Model state: phase index 0..7 (A1..X3), clocks into the phase, captured words.
  typedef struct {
    int         pre;
    int         ph;
    bit         second;
    bit         fin;
    logic [7:0] w1;
    logic [7:0] w2;
    bit         stopped;
  } mstate_t;

  mstate_t m1, m3;

  // 0 = one-word, 1 = two-word, 2 = FIN
  function automatic int kind(logic [7:0] w);
    case (w[7:4])
      4'h1, 4'h4, 4'h5, 4'h7: return 1;
      4'h2:                   return w[0] ? 0 : 1;
      4'h3:                   return w[0] ? 0 : 2;
      default:                return 0;
    endcase
  endfunction

  function automatic mstate_t m_reset();
    mstate_t m;
    m.pre = 0; m.ph = 0; m.second = 0; m.fin = 0;
    m.w1 = 8'h00; m.w2 = 8'h00; m.stopped = 0;
    return m;
  endfunction

  function automatic bit m_tick(mstate_t m, int div, logic run, logic rstv);
    return run && !rstv && !m.stopped && (m.pre == div - 1);
  endfunction

  function automatic bit m_done(mstate_t m, bit t);
    return t && (m.ph == 7) && (m.second || kind(m.w1) == 0);
  endfunction

  function automatic mstate_t m_next(mstate_t m, int div, logic run, logic [3:0] d, logic stop);
    mstate_t n;
    bit      t;
    n = m;
    t = m_tick(m, div, run, 1'b0);
    if (m.stopped) begin
      if (!stop) n.stopped = 0;
      return n;
    end
    if (!t) begin
      if (run) n.pre = m.pre + 1;
      return n;
    end
    n.pre = 0;
    n.ph  = (m.ph + 1) % 8;
    if (m.ph == 3) begin
      if (m.second) n.w2[7:4] = d; else n.w1[7:4] = d;
    end
    if (m.ph == 4) begin
      if (m.second) n.w2[3:0] = d; else n.w1[3:0] = d;
    end
    if (m.ph == 7) begin
      if (m_done(m, t) && stop) n.stopped = 1;
      if (m.second) begin
        n.second = 0; n.fin = 0;
      end else begin
        n.second = (kind(m.w1) != 0);
        n.fin    = (kind(m.w1) == 2);
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = m_reset();
      m3 = m_reset();
    end else begin
      m1 = m_next(m1, 1, run_en, data_in, stop_req);
      m3 = m_next(m3, 3, run_en, data_in, stop_req);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_inst(input string tag, input mstate_t m, input int div,
                              input logic [2:0] cyc, input logic tk, input logic sy,
                              input logic [7:0] i1, input logic [7:0] i2,
                              input logic sc, input logic fc, input logic pc,
                              input logic cr, input logic cm, input logic dn);
    bit t, cmx;
    t   = m_tick(m, div, run_en, rst);
    cmx = (m.ph == 2)
       || (!m.second && m.ph == 4 && m.w1[7:4] == 4'hE)
       || (!m.second && m.ph == 6 && m.w1[7:4] == 4'h2 && m.w1[0]);
    checkOutput({tag, ".cyc"},          {5'b0, cyc}, 8'(m.ph));
    checkOutput({tag, ".phase_tick"},   8'(tk), 8'(t));
    checkOutput({tag, ".sync"},         8'(sy), 8'(m.ph == 7));
    checkOutput({tag, ".instr"},        i1, m.w1);
    checkOutput({tag, ".instr2"},       i2, m.w2);
    checkOutput({tag, ".second_cycle"}, 8'(sc), 8'(m.second));
    checkOutput({tag, ".fin_cycle"},    8'(fc), 8'(m.fin));
    checkOutput({tag, ".pc_inc"},       8'(pc), 8'(t && m.ph == 4 && !m.fin));
    checkOutput({tag, ".cm_rom"},       8'(cr), 8'(cmx));
    checkOutput({tag, ".cm_ram"},       8'(cm), 8'(cmx));
    checkOutput({tag, ".instr_done"},   8'(dn), 8'(m_done(m, t)));
  endtask

  // Per-cycle comparison of both instances plus pulse counters for the Clk_div=1 instance.
  always @(negedge clk) begin
    compare_inst("d1", m1, 1, bus1.cyc, bus1.phase_tick, bus1.sync, bus1.instr, bus1.instr2,
                 bus1.second_cycle, bus1.fin_cycle, bus1.pc_inc, bus1.cm_rom, bus1.cm_ram,
                 bus1.instr_done);
    compare_inst("d3", m3, 3, bus3.cyc, bus3.phase_tick, bus3.sync, bus3.instr, bus3.instr2,
                 bus3.second_cycle, bus3.fin_cycle, bus3.pc_inc, bus3.cm_rom, bus3.cm_ram,
                 bus3.instr_done);
`ifdef MCS4_STOP_EN
    checkOutput("d1.stop_ack", 8'(bus1.stop_ack), 8'(m1.stopped));
    checkOutput("d3.stop_ack", 8'(bus3.stop_ack), 8'(m3.stopped));
`endif
    if (bus1.pc_inc)     pc_cnt++;
    if (bus1.instr_done) done_cnt++;
    if (bus1.sync)       sync_cnt++;
    if (bus1.cm_rom)     cm_rom_cnt++;
    if (bus1.cm_ram)     cm_ram_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    pc_cnt = 0; done_cnt = 0; sync_cnt = 0; cm_rom_cnt = 0; cm_ram_cnt = 0;
  endtask

  // Presents one machine cycle on the bus: OPR nibble during M1, OPA nibble during M2.
  task automatic applyStimulus(input logic [7:0] w, input int div);
    for (int p = 0; p < 8; p++) begin
      data_in = (p == 3) ? w[7:4] : (p == 4) ? w[3:0] : 4'h0;
      step(div);
    end
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b1; data_in = 4'h0; stop_req = 1'b0;
    clear_counts();
    #1;
    checkOutput("reset.cyc",        {5'b0, bus1.cyc}, 8'(A1));
    checkOutput("reset.phase_tick", 8'(bus1.phase_tick), 8'h00);
    checkOutput("reset.pc_inc",     8'(bus1.pc_inc), 8'h00);
    checkOutput("reset.instr",      bus1.instr, 8'h00);
    checkOutput("reset.instr2",     bus1.instr2, 8'h00);
    step(1);
    rst = 1'b0;

    clear_counts();
    applyStimulus(8'hF2, 1);
    checkOutput("iac.instr",  bus1.instr, 8'hF2);
    checkOutput("iac.second", 8'(bus1.second_cycle), 8'h00);
    checkOutput("iac.pc_cnt", 8'(pc_cnt), 8'd1);
    checkOutput("iac.done",   8'(done_cnt), 8'd1);
    checkOutput("iac.sync",   8'(sync_cnt), 8'd1);

    clear_counts();
    applyStimulus(8'h40, 1);
    checkOutput("jun.second1", 8'(bus1.second_cycle), 8'h01);
    checkOutput("jun.done1",   8'(done_cnt), 8'd0);
    applyStimulus(8'h12, 1);
    checkOutput("jun.instr",   bus1.instr, 8'h40);
    checkOutput("jun.instr2",  bus1.instr2, 8'h12);
    checkOutput("jun.second2", 8'(bus1.second_cycle), 8'h00);
    checkOutput("jun.pc_cnt",  8'(pc_cnt), 8'd2);
    checkOutput("jun.done",    8'(done_cnt), 8'd1);

    clear_counts();
    applyStimulus(8'h30, 1);
    checkOutput("fin.fin_cycle", 8'(bus1.fin_cycle), 8'h01);
    checkOutput("fin.second",    8'(bus1.second_cycle), 8'h01);
    applyStimulus(8'h00, 1);
    checkOutput("fin.cleared", 8'(bus1.fin_cycle), 8'h00);
    checkOutput("fin.pc_cnt",  8'(pc_cnt), 8'd1);
    checkOutput("fin.done",    8'(done_cnt), 8'd1);

    clear_counts();
    applyStimulus(8'h21, 1);
    checkOutput("src.cm_rom_cnt", 8'(cm_rom_cnt), 8'd2);
    checkOutput("src.cm_ram_cnt", 8'(cm_ram_cnt), 8'd2);
    clear_counts();
    applyStimulus(8'hE0, 1);
    checkOutput("wrm.cm_rom_cnt", 8'(cm_rom_cnt), 8'd2);
    checkOutput("wrm.cm_ram_cnt", 8'(cm_ram_cnt), 8'd2);
    checkOutput("wrm.instr",      bus1.instr, 8'hE0);

    // Clk_div=3: phase length, run_en freeze inside M1, reset during X1.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    data_in = 4'hA;
    step(2);
    checkOutput("div3.hold_a1", {5'b0, bus3.cyc}, 8'(A1));
    step(1);
    checkOutput("div3.a2", {5'b0, bus3.cyc}, 8'(A2));
    step(7);
    checkOutput("div3.m1", {5'b0, bus3.cyc}, 8'(M1));
    run_en = 1'b0;
    step(5);
    checkOutput("div3.frozen",      {5'b0, bus3.cyc}, 8'(M1));
    checkOutput("div3.frozen_tick", 8'(bus3.phase_tick), 8'h00);
    run_en = 1'b1;
    step(1);
    checkOutput("div3.tick", 8'(bus3.phase_tick), 8'h01);
    step(1);
    checkOutput("div3.m2", {5'b0, bus3.cyc}, 8'(M2));
    step(4);
    checkOutput("div3.x1", {5'b0, bus3.cyc}, 8'(X1));
    rst = 1'b1;
    #1;
    checkOutput("div3.rst_cyc",    {5'b0, bus3.cyc}, 8'(A1));
    checkOutput("div3.rst_pc",     8'(bus3.pc_inc), 8'h00);
    checkOutput("div3.rst_done",   8'(bus3.instr_done), 8'h00);
    checkOutput("div3.rst_tick",   8'(bus3.phase_tick), 8'h00);
    checkOutput("div3.rst_second", 8'(bus3.second_cycle), 8'h00);
    step(1);
    rst = 1'b0;
    data_in = 4'h0;
    step(3);
    checkOutput("div3.restart", {5'b0, bus3.cyc}, 8'(A2));

`ifdef MCS4_STOP_EN
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    stop_req = 1'b1;
    clear_counts();
    applyStimulus(8'h50, 1);
    checkOutput("stop.not_yet", 8'(bus1.stop_ack), 8'h00);
    checkOutput("stop.second",  8'(bus1.second_cycle), 8'h01);
    applyStimulus(8'h23, 1);
    checkOutput("stop.ack",  8'(bus1.stop_ack), 8'h01);
    checkOutput("stop.cyc",  {5'b0, bus1.cyc}, 8'(A1));
    checkOutput("stop.done", 8'(done_cnt), 8'd1);
    step(3);
    checkOutput("stop.hold_ack", 8'(bus1.stop_ack), 8'h01);
    checkOutput("stop.hold_cyc", {5'b0, bus1.cyc}, 8'(A1));
    stop_req = 1'b0;
    step(1);
    checkOutput("stop.released", 8'(bus1.stop_ack), 8'h00);
    checkOutput("stop.rel_cyc",  {5'b0, bus1.cyc}, 8'(A1));
    clear_counts();
    applyStimulus(8'hF2, 1);
    checkOutput("stop.resume_done",  8'(done_cnt), 8'd1);
    checkOutput("stop.resume_instr", bus1.instr, 8'hF2);
`endif

    step(2);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcs4_cycle_seq.md
Name: mcs4_cycle_seq

Overview:
- Instruction-cycle sequencer for the MCS-4 CPU core.
- Steps the eight-phase machine cycle A1, A2, A3, M1, M2, X1, X2, X3, generates SYNC and command-line (CM-ROM/CM-RAM) timing, and latches OPR/OPA from the 4-bit bus.
- Detects two-word instructions and sequences their second cycle.
- Sits between the external 4-bit bus and the core's decode/execute datapath; drives PC-increment and instruction-complete strobes.

Parameters:
- Clk_div, 1, clk cycles per phase tick (1..16); 1 means a tick every clk.
- Cycles_per_instruction, mcs4::Cycles_per_instruction (8), phases per machine cycle; any other value is an elaboration error.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- run_en  input  1  global run enable; low freezes the prescaler and phase.
- data_in  input  4  bus nibble, sampled on ticks in M1 and M2.
- cyc  output  3  current phase, type mcs4::instr_cyc_t.
- phase_tick  output  1  one-clk pulse on the clk where the phase advances.
- sync  output  1  high for all of X3.
- instr  output  8  latched first word (mcs4::instr_t: opr, opa).
- instr2  output  8  latched second word (mcs4::instr2_t).
- second_cycle  output  1  the current machine cycle is the second cycle of a two-word instruction.
- fin_cycle  output  1  the current second cycle belongs to FIN (indirect fetch).
- pc_inc  output  1  one-clk pulse: increment the PC.
- cm_rom  output  1  CM-ROM line.
- cm_ram  output  1  CM-RAM line (bank gating happens downstream).
- instr_done  output  1  one-clk pulse: instruction fully fetched; execute may commit.

Behaviour:
- Reset values (async, immediate): cyc=A1, prescale count=0, instr=0, instr2=0, second_cycle=0, fin_cycle=0. sync, pc_inc, cm_rom, cm_ram, instr_done and phase_tick are all 0.
- Prescaler: counts 0..Clk_div-1 while run_en=1. phase_tick=1 when count==Clk_div-1 and run_en=1; the count then wraps to 0. run_en=0 holds the count and phase.
- Phase: on each tick, cyc advances A1→…→X3→A1 (3-bit wrap).
- sync is combinational: (cyc==X3).
- Latching, first cycle: on the tick leaving M1, instr.opr<=data_in; on the tick leaving M2, instr.opa<=data_in.
- Latching, second cycle: the same ticks load instr2.op_b and instr2.op_c; instr is held.
- Two-word decode, evaluated on the tick leaving X3 with second_cycle=0:
  - JCN (opr=1), FIM (opr=2, opa[0]=0), JUN (opr=4), JMS (opr=5), ISZ (opr=7) set second_cycle.
  - FIN (opr=3, opa[0]=0) sets second_cycle and fin_cycle.
  - All others leave both flags 0.
- On the tick leaving X3 with second_cycle=1: both flags clear.
- pc_inc pulses with the tick leaving M2, in every machine cycle except those with fin_cycle=1.
- instr_done pulses with the tick leaving X3 when the instruction is complete: a one-word first cycle, or any second cycle.
- cm_rom and cm_ram, combinational:
  - High in A3.
  - High in M2 when second_cycle=0 and instr.opr==4'hE.
  - High in X2 when second_cycle=0 and instr is SRC (opr=2, opa[0]=1).
  - Low otherwise.
- Boundaries:
  - Clk_div=1 gives a tick on every clk.
  - run_en dropping mid-phase freezes all state; outputs stay stable apart from the pulses, which are gated to 0.
  - rst mid-cycle aborts the instruction; the next machine cycle starts at A1 as a first cycle.

Optional Feature:
- MCS4_STOP_EN present:
  - Adds input stop_req (1) and output stop_ack (1, reset 0).
  - If stop_req=1 at the tick where instr_done pulses, the sequencer enters STOPPED: cyc=A1, ticks suppressed, stop_ack=1.
  - It leaves STOPPED on the first clk with stop_req=0; stop_ack then clears and the prescaler restarts at 0.
  - stop_req is never honoured between the two cycles of a two-word instruction.
- MCS4_STOP_EN absent: no ports, no STOPPED state.

Decomposition:
- Package mcs4 additions:
  - function is_two_word(instr_t)
  - function is_fin(instr_t)
  - function is_src(instr_t)
  - function is_io(instr_t), true for opr==E
  - localparam Max_clk_div = 16
- Phase encoding reuses mcs4::instr_cyc_t.
- One sub-module: mcs4_phase_prescaler, the tick generator (clk, rst, run_en → phase_tick).

Test Plan:
- Reset with Clk_div=1, run_en=1, bus feeding 0xF2 (IAC) → cyc sequence A1..X3 over 8 clks; sync only in X3; pc_inc once; instr_done once; instr=0xF2; second_cycle stays 0.
- Bus feeds 0x40 then 0x12 (JUN 0x012) → second_cycle=1 for cycle 2; instr=0x40, instr2=0x12; pc_inc twice; instr_done only at the end of cycle 2.
- FIN (0x30) → fin_cycle=1 for cycle 2; pc_inc absent in cycle 2; instr_done at the end of cycle 2.
- SRC (0x21), then WRM (0xE0) → cm_rom/cm_ram high in A3 and X2 of the SRC cycle; in the WRM cycle high in A3 and M2; low elsewhere.
- Clk_div=3, run_en low for 5 clks during M1, rst pulsed during X1 → phase lasts 3 clks; freeze holds cyc=M1; reset forces A1 immediately with all pulses 0.
- With MCS4_STOP_EN defined, stop_req=1 during a JMS first cycle → halt only after the second-cycle instr_done; stop_ack=1, cyc=A1; releasing stop_req resumes at A1.
